// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : pipeline types and RV32 load/store constants for the MEM stage
// Revision      : 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int RegWidth = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic       valid;
        logic       mem_rd;
        logic       mem_wr;
        logic       wb_en;
        logic [2:0] func3;
    } ctrl_t;

    typedef struct packed {
        logic [4:0]          addr;
        logic [RegWidth-1:0] value;
    } rd_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [RegWidth-1:0] rs;
        rd_t                 rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t ctrl;
        rd_t   rd;
    } mem_wb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } mem_state_e;

    localparam mem_wb_t cBubble = '0;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// mem_lsu_align : byte enables, store lane replication, load extraction/extension
// Revision      : 1.0
// ============================================================================
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic        isStore,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] loadData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeLanes,
    output logic [31:0] loadValue,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  wByte;
    logic [15:0] wHalf;

    assign wByte = loadData[{addrLo, 3'b000} +: 8];
    assign wHalf = addrLo[1] ? loadData[31:16] : loadData[15:0];

    always_comb begin
        byteEn     = '0;
        storeLanes = '0;
        loadValue  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (isStore) begin
            case (func3)
                F3_SB: begin
                    byteEn     = 4'b0001 << addrLo;
                    storeLanes = {4{storeData[7:0]}};
                end
                F3_SH: begin
                    byteEn     = 4'b0011 << {addrLo[1], 1'b0};
                    storeLanes = {2{storeData[15:0]}};
                    misaligned = addrLo[0];
                end
                F3_SW: begin
                    byteEn     = 4'b1111;
                    storeLanes = storeData;
                    misaligned = (addrLo != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB:  loadValue = {{24{wByte[7]}}, wByte};
                F3_LH: begin
                    loadValue  = {{16{wHalf[15]}}, wHalf};
                    misaligned = addrLo[0];
                end
                F3_LW: begin
                    loadValue  = loadData;
                    misaligned = (addrLo != 2'b00);
                end
                F3_LBU: loadValue = {24'd0, wByte};
                F3_LHU: begin
                    loadValue  = {16'd0, wHalf};
                    misaligned = addrLo[0];
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage, load/store over a req/ack bus with stall, hold and timeout
// Revision  : 1.0
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TimeoutCycles = 255
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iEn,
    input  logic                iStall,
    input  ex_mem_t             iEX,
    output logic                oStall,
    output mem_wb_t             oWB,
    output logic [RegWidth-1:0] oFwMe,
    output logic                oDmemReq,
    output logic                oDmemWe,
    output logic [31:0]         oDmemAddr,
    output logic [31:0]         oDmemWData,
    output logic [3:0]          oDmemBe,
    input  logic                iDmemAck,
    input  logic [31:0]         iDmemRData,
    input  logic                iDmemErr,
    output logic                oMisalign,
    output logic                oBusErr
);

    // Counter holds BUSY cycles already spent, so this value marks the last allowed one
    localparam logic [7:0] cTimeoutLast = 8'(TimeoutCycles - 1);

    mem_state_e  rState, wNextState;
    ctrl_t       rCtrl;
    logic [4:0]  rRdAddr;
    logic [1:0]  rLane;
    mem_wb_t     rHold;
    logic [7:0]  rCtr;

    logic        wMemop, wBad, wMisaligned, wIllegal;
    logic [2:0]  wAlignF3;
    logic [1:0]  wAlignLane;
    logic        wAlignStore;
    logic [3:0]  wBe;
    logic [31:0] wStoreLanes, wLoadValue;
    logic        wTimeout, wDone, wFail;
    mem_wb_t     wResult;

    assign wMemop = iEX.ctrl.valid & (iEX.ctrl.mem_rd | iEX.ctrl.mem_wr);
    assign wBad   = wMisaligned | wIllegal;

    // One aligner serves the issue side in IDLE and the response side afterwards
    assign wAlignF3    = (rState == IDLE) ? iEX.ctrl.func3     : rCtrl.func3;
    assign wAlignLane  = (rState == IDLE) ? iEX.rd.value[1:0]  : rLane;
    assign wAlignStore = (rState == IDLE) ? iEX.ctrl.mem_wr    : rCtrl.mem_wr;

    mem_lsu_align u_align (
        .func3      (wAlignF3),
        .isStore    (wAlignStore),
        .addrLo     (wAlignLane),
        .storeData  (iEX.rs),
        .loadData   (iDmemRData),
        .byteEn     (wBe),
        .storeLanes (wStoreLanes),
        .loadValue  (wLoadValue),
        .misaligned (wMisaligned),
        .illegal    (wIllegal)
    );

    assign wTimeout = !iDmemAck && (rCtr == cTimeoutLast);
    assign wDone    = iDmemAck | wTimeout;
    assign wFail    = iDmemAck ? iDmemErr : 1'b1;
    assign oFwMe    = oWB.rd.value;

    always_comb begin
        wResult = cBubble;
        if (!wFail) begin
            wResult.ctrl     = rCtrl;
            wResult.rd.addr  = rRdAddr;
            wResult.rd.value = rCtrl.mem_wr ? '0 : wLoadValue;
        end
    end

    always_comb begin
        wNextState = rState;
        oStall     = 1'b0;
        case (rState)
            IDLE: begin
                oStall = iStall | (wMemop & !wBad);
                if (!iStall && wMemop && !wBad) wNextState = BUSY;
            end
            BUSY: begin
                oStall = !(wDone & !iStall);
                if (wDone) wNextState = iStall ? HOLD : IDLE;
            end
            HOLD: begin
                // Release cycle lets EX advance so the held instruction is not reissued
                oStall = iStall;
                if (!iStall) wNextState = IDLE;
            end
            default: wNextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            rState     <= IDLE;
            oWB        <= '0;
            rHold      <= '0;
            rCtrl      <= '0;
            rRdAddr    <= '0;
            rLane      <= '0;
            rCtr       <= '0;
            oDmemReq   <= 1'b0;
            oDmemWe    <= 1'b0;
            oDmemAddr  <= '0;
            oDmemWData <= '0;
            oDmemBe    <= '0;
            oMisalign  <= 1'b0;
            oBusErr    <= 1'b0;
        end else if (iEn) begin
            rState    <= wNextState;
            oMisalign <= 1'b0;
            oBusErr   <= 1'b0;
            case (rState)
                IDLE: begin
                    if (!iStall) begin
                        if (wMemop && wBad) begin
                            oWB       <= cBubble;
                            oMisalign <= wMisaligned;
                            oBusErr   <= wIllegal;
                        end else if (wMemop) begin
                            rCtrl      <= iEX.ctrl;
                            rRdAddr    <= iEX.rd.addr;
                            rLane      <= iEX.rd.value[1:0];
                            rCtr       <= '0;
                            oDmemReq   <= 1'b1;
                            oDmemWe    <= iEX.ctrl.mem_wr;
                            oDmemAddr  <= {iEX.rd.value[31:2], 2'b00};
                            oDmemWData <= wStoreLanes;
                            oDmemBe    <= iEX.ctrl.mem_wr ? wBe : 4'b1111;
                        end else begin
                            oWB <= '{ctrl: iEX.ctrl, rd: iEX.rd};
                        end
                    end
                end
                BUSY: begin
                    if (wDone) begin
                        oDmemReq <= 1'b0;
                        oDmemWe  <= 1'b0;
                        oBusErr  <= wFail;
                        if (iStall) rHold <= wResult;
                        else        oWB   <= wResult;
                    end else if (rCtr != 8'hFF) begin
                        rCtr <= rCtr + 8'd1;
                    end
                end
                HOLD: begin
                    if (!iStall) oWB <= rHold;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
